// File: rtl/datapath_pkg.sv
// Shared encodings for the self-sequencing datapath.
package datapath_pkg;

    // ALU function applied to the a/b operands in EXEC
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    // Single-bit shift applied to the B register before it reaches the ALU
    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_op_e;

    // Source of the value written back to rd
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_PC  = 2'b01,
        WB_IMM = 2'b10,
        WB_MEM = 2'b11
    } wb_sel_e;

    // Operation sequencer; non-ALU write-backs jump IDLE -> WRITE
    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WRITE
    } state_e;

endpackage

// File: rtl/regfile_p.sv
// General register file: one synchronous write port, one asynchronous read
// port, whole array cleared by a synchronous reset.
module regfile_p
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [RAW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RAW-1:0]   raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] regs [NREGS];

    // Register storage: clear everything on reset, otherwise single write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous read port
    always_comb begin
        rdata = regs[raddr];
    end

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: accepts one operation per valid/ready handshake
// and walks it through register read, execute and write-back internally.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 8,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [RAW-1:0]   rd,
    input  logic [RAW-1:0]   rn,
    input  logic [RAW-1:0]   rm,
    input  logic [1:0]       alu_op,
    input  logic [1:0]       shift_op,
    input  logic             sel_a_zero,
    input  logic             sel_b_imm,
    input  logic [WIDTH-1:0] imm,
    input  logic [1:0]       wb_sel,
    input  logic             wr_en,
    input  logic             set_status,
    input  logic [WIDTH-1:0] mdata,
    input  logic [PCW-1:0]   pc,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic             z_out,
    output logic             n_out,
    output logic             v_out
);

    state_e state, state_n;

    // Operation fields captured at accept
    logic [RAW-1:0]   q_rd, q_rn, q_rm;
    alu_op_e          q_alu_op;
    shift_op_e        q_shift_op;
    logic             q_sel_a_zero, q_sel_b_imm;
    logic [WIDTH-1:0] q_imm;
    wb_sel_e          q_wb_sel;
    logic             q_wr_en, q_set_status;

    // Datapath registers
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             z_q, n_q, v_q;

    // Register file interface
    logic             rf_we;
    logic [RAW-1:0]   rf_raddr;
    logic [WIDTH-1:0] rf_rdata;
    logic [WIDTH-1:0] wb_data;

    // Combinational ALU/shifter results
    logic [WIDTH-1:0] b_shift, a_opnd, b_opnd, alu_res;
    logic             alu_z, alu_n, alu_v;

    logic accept;

    assign accept = op_valid && op_ready;

    regfile_p #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (q_rd),
        .wdata (wb_data),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic with handshake and done outputs
    always_comb begin
        state_n  = state;
        op_ready = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_n = (wb_sel_e'(wb_sel) == WB_ALU) ? LOAD_A : WRITE;
                end
            end
            LOAD_A: state_n = LOAD_B;
            LOAD_B: state_n = EXEC;
            EXEC:   state_n = WRITE;
            WRITE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture all operation fields on the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            q_rd         <= '0;
            q_rn         <= '0;
            q_rm         <= '0;
            q_alu_op     <= ALU_ADD;
            q_shift_op   <= SH_NONE;
            q_sel_a_zero <= 1'b0;
            q_sel_b_imm  <= 1'b0;
            q_imm        <= '0;
            q_wb_sel     <= WB_ALU;
            q_wr_en      <= 1'b0;
            q_set_status <= 1'b0;
        end else if (accept) begin
            q_rd         <= rd;
            q_rn         <= rn;
            q_rm         <= rm;
            q_alu_op     <= alu_op_e'(alu_op);
            q_shift_op   <= shift_op_e'(shift_op);
            q_sel_a_zero <= sel_a_zero;
            q_sel_b_imm  <= sel_b_imm;
            q_imm        <= imm;
            q_wb_sel     <= wb_sel_e'(wb_sel);
            q_wr_en      <= wr_en;
            q_set_status <= set_status;
        end
    end

    // The single read port is shared: rm during LOAD_B, rn otherwise
    always_comb begin
        rf_raddr = (state == LOAD_B) ? q_rm : q_rn;
    end

    // Operand latches loaded in LOAD_A / LOAD_B
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (state == LOAD_A) begin
                a_q <= rf_rdata;
            end
            if (state == LOAD_B) begin
                b_q <= rf_rdata;
            end
        end
    end

    // B shifter: lsl drops the MSB, lsr fills zero, asr keeps the sign
    always_comb begin
        b_shift = b_q;
        unique case (q_shift_op)
            SH_NONE: b_shift = b_q;
            SH_LSL1: b_shift = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR1: b_shift = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR1: b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: b_shift = b_q;
        endcase
    end

    // ALU with Z/N/V flag generation; arithmetic wraps modulo 2^WIDTH
    always_comb begin
        a_opnd  = q_sel_a_zero ? '0 : a_q;
        b_opnd  = q_sel_b_imm ? q_imm : b_shift;
        alu_res = '0;
        alu_v   = 1'b0;
        unique case (q_alu_op)
            ALU_ADD: begin
                alu_res = a_opnd + b_opnd;
                alu_v   = (a_opnd[WIDTH-1] == b_opnd[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_opnd[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = a_opnd - b_opnd;
                alu_v   = (a_opnd[WIDTH-1] != b_opnd[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_opnd[WIDTH-1]);
            end
            ALU_AND: alu_res = a_opnd & b_opnd;
            ALU_NOT: alu_res = ~b_opnd;
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == '0);
        alu_n = alu_res[WIDTH-1];
    end

    // C register and status flags, updated only in EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state == EXEC) begin
            c_q <= alu_res;
            if (q_set_status) begin
                z_q <= alu_z;
                n_q <= alu_n;
                v_q <= alu_v;
            end
        end
    end

    // Write-back source select; pc and mdata are sampled live in WRITE
    always_comb begin
        wb_data = '0;
        unique case (q_wb_sel)
            WB_ALU: wb_data = c_q;
            WB_PC:  wb_data[PCW-1:0] = pc;
            WB_IMM: wb_data = q_imm;
            WB_MEM: wb_data = mdata;
            default: wb_data = '0;
        endcase
    end

    // Register write strobe
    always_comb begin
        rf_we = (state == WRITE) && q_wr_en;
    end

    // Output drive
    always_comb begin
        datapath_out = c_q;
        z_out        = z_q;
        n_out        = n_q;
        v_out        = v_q;
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, self-sequencing successor to the CPU datapath.
- Accepts one operation per valid/ready handshake and walks it through register-read, execute and write-back with an internal FSM, instead of an external controller driving every enable.
- Adds WIDTH and register-count generics, a register-file reset, a fast path for non-ALU write-backs, and a done pulse.
- Sits between the instruction decoder/controller and memory.

Parameters:
- WIDTH, 16, datapath word width (min 4).
- NREGS, 8, number of general registers (power of two, min 2); RAW = $clog2(NREGS).
- PCW, 8, program-counter width (PCW <= WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation offered
- op_ready  out  1  block can accept an operation
- rd  in  RAW  destination register
- rn  in  RAW  A-operand register
- rm  in  RAW  B-operand register
- alu_op  in  2  00 add, 01 sub (A-B), 10 and, 11 not B
- shift_op  in  2  B shift: 00 none, 01 lsl1, 10 lsr1, 11 asr1
- sel_a_zero  in  1  force A operand to 0
- sel_b_imm  in  1  B operand = imm instead of shifted register
- imm  in  WIDTH  immediate, already sign-extended by the decoder
- wb_sel  in  2  00 ALU result C, 01 zero-extended pc, 10 imm, 11 mdata
- wr_en  in  1  write the result to rd
- set_status  in  1  update Z/N/V
- mdata  in  WIDTH  memory read data; sampled in WRITE
- pc  in  PCW  program counter; sampled in WRITE
- done  out  1  one-cycle pulse in the WRITE cycle
- datapath_out  out  WIDTH  C register
- z_out  out  1  status flag Z
- n_out  out  1  status flag N
- v_out  out  1  status flag V

Behaviour:
- Reset: FSM to IDLE; op_ready=1, done=0, datapath_out=0, z/n/v=0; all NREGS registers and the A/B latches cleared. Reset mid-operation aborts the op with no write-back.
- Handshake: op_ready=1 only in IDLE. Accept when op_valid&&op_ready; all op fields are captured on that edge and inputs may change afterwards. op_valid while busy is ignored and does not queue.
- FSM for ALU ops (wb_sel=00), with accept on the edge ending cycle 0:
  - LOAD_A (cycle 1): A <= R[rn].
  - LOAD_B (cycle 2): B <= R[rm].
  - EXEC (cycle 3): C <= ALU result; flags <= new flags if set_status.
  - WRITE (cycle 4): done=1; R[rd] <= C if wr_en.
  - IDLE (cycle 5): op_ready=1 again.
- Fast path: wb_sel != 00 goes IDLE -> WRITE directly. done is in cycle 1; C and flags are untouched.
- Write-back value in WRITE: C, {0,pc}, imm or mdata per wb_sel.
- A stale read is impossible: ops are serialised, so a write in WRITE is visible to the next op's LOAD_A.
- Operands: a = sel_a_zero ? 0 : A; b = sel_b_imm ? imm : shift(B).
  - lsr fills 0; asr replicates the MSB; lsl drops the MSB.
- Arithmetic: modulo 2^WIDTH; carry is not kept.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V = signed overflow: add when a,b MSBs are equal and differ from the result MSB; sub when a,b MSBs differ and the result MSB differs from a's MSB. V=0 for and/not.
- rd may equal rn/rm. Writing the same register twice in consecutive ops is legal; the last write wins.

Decomposition:
- Package datapath_pkg: alu_op_e, shift_op_e, wb_sel_e enums; state_e {IDLE, LOAD_A, LOAD_B, EXEC, WRITE}.
- Sub-module regfile_p #(WIDTH, NREGS): 1 write port, 1 async read port, synchronous clear on reset.
- ALU and shifter are combinational always_comb blocks inside datapath_seq.

Test Plan:
- Reset then load R0=7 via wb_sel=10, imm=7, wr_en=1 -> op_ready drops; done in cycle 1; R0=7; datapath_out stays 0.
- R0=7, R1=2; add rd=2, rn=0, rm=1, shift lsl1, set_status -> done in cycle 4; datapath_out=11; R2=11; Z=N=V=0.
- WIDTH=16: R0=0x7FFF, imm=1, sel_b_imm, add, set_status -> C=0x8000, N=1, V=1, Z=0. Then sub 5-5 -> Z=1, V=0.
- Toggle op_valid with different fields during EXEC -> ignored; only the first op's result is written; the next accept happens in cycle 5.
- Assert reset in the EXEC cycle of an add with rd=3 -> R3=0, outputs 0, op_ready=1 the next cycle, no done pulse.
- Rerun the add scenario with NREGS=16, WIDTH=8 using rd=15 -> result wraps mod 256 and lands in R15.
